// File: rtl/conv_code_pkg.sv
// Shared convolutional-code definitions: default word size, constraint length,
// generator polynomials and the encoder FSM state encoding.
// The Viterbi decoder imports the same package so both sides agree on the code.
package conv_code_pkg;

  // Information bits per word
  localparam int CONV_DATA_W = 14;
  // Constraint length: an 8-state trellis
  localparam int CONV_K = 4;
  // Generator polynomials; the MSB taps the current input bit
  localparam logic [CONV_K-1:0] CONV_G0 = 4'b1111;
  localparam logic [CONV_K-1:0] CONV_G1 = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 output pair for one trellis step.
// Zero latency; no flow control, it is a pure function of the window.
// pair_o = {c0, c1} with c0/c1 the parities of the window masked by G0/G1.
module conv_enc_core #(
  parameter int             K  = 4,
  parameter logic [K-1:0]   G0 = 4'b1111,
  parameter logic [K-1:0]   G1 = 4'b1101
) (
  input  logic [K-1:0] w_i,
  output logic [1:0]   pair_o
);

  assign pair_o = {^(w_i & G0), ^(w_i & G1)};

endmodule

// File: rtl/conv_encoder.sv
// Word-serial convolutional encoder: latches a DATA_W word on start and emits a
// packed 2*DATA_W codeword DATA_W+1 cycles later with a one-cycle done pulse.
// start is only honoured in IDLE; busy covers ENC and DONE. Optional macro
// CONV_ENC_SERIAL_EN adds a per-cycle code_bit/code_bit_valid stream.
module conv_encoder
  import conv_code_pkg::*;
#(
  parameter int             DATA_W = CONV_DATA_W,
  parameter int             K      = CONV_K,
  parameter logic [K-1:0]   G0     = CONV_G0,
  parameter logic [K-1:0]   G1     = CONV_G1,
  localparam int            CODE_W = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [CODE_W-1:0] code,
`ifdef CONV_ENC_SERIAL_EN
  output logic [1:0]        code_bit,
  output logic              code_bit_valid,
`endif
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [K-2:0]      hist_q, hist_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic              cur_bit;
  logic [K-1:0]      win;
  logic [1:0]        pair;

  // Current bit is taken MSB first by indexing with the down-counter
  assign cur_bit = data_q[cnt_q];
  assign win     = {cur_bit, hist_q};

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .w_i    (win),
    .pair_o (pair)
  );

  // Next-state logic: accept, step one bit per ENC cycle, publish on entry to DONE
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ENC;
          data_d   = data;
          hist_d   = '0;
          cnt_d    = CNT_W'(DATA_W - 1);
          shadow_d = '0;
        end
      end
      ST_ENC: begin
        shadow_d[{cnt_q, 1'b0} +: 2] = pair;
        hist_d = win[K-1:1];
        if (cnt_q == '0) begin
          // Last pair goes straight into the visible code with the rest of the word
          state_d = ST_DONE;
          code_d  = shadow_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // Start is deliberately not looked at here
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any word in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      hist_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign code = code_q;

`ifdef CONV_ENC_SERIAL_EN
  assign code_bit_valid = (state_q == ST_ENC);
  assign code_bit       = (state_q == ST_ENC) ? pair : 2'b00;
`endif

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter DATA_W, default 14, meaning information bits per word; CODE_W = 2*DATA_W.
REQ-002 Parameter K, default 4, meaning constraint length (8-state trellis).
REQ-003 Parameter G0, default 4'b1111, meaning first generator polynomial, MSB taps current bit.
REQ-004 Parameter G1, default 4'b1101, meaning second generator polynomial, MSB taps current bit.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to encode data; honoured only in IDLE.
REQ-008 data  input  DATA_W  information word, sampled on the accepted start cycle.
REQ-009 busy  output  1  high in ENC and DONE.
REQ-010 code  output  CODE_W  packed codeword, held until the next done.
REQ-011 done  output  1  one-cycle pulse when code is updated.

Function
REQ-012 The FSM SHALL have states IDLE, ENC and DONE: IDLE->ENC on start; ENC->DONE after DATA_W bit cycles; DONE->IDLE unconditionally.
REQ-013 On accepted start, data SHALL be latched, the K-1 bit history register cleared to 0, and bit counter loaded with DATA_W-1.
REQ-014 ENC SHALL process one bit per cycle, data MSB first.
REQ-015 Window w = {u_t, u_t-1, u_t-2, u_t-3}; c0 = XOR-reduce(w & G0); c1 = XOR-reduce(w & G1).
REQ-016 The pair for bit index i (counting down from DATA_W-1) SHALL be written to code[2i+1:2i] as {c0,c1}.
REQ-017 code SHALL be built in a shadow register and copied to code on entry to DONE, so code never shows partial words.
REQ-018 done SHALL be high only in DONE; latency from accepted start to done = DATA_W+1 cycles (15 at default).
REQ-019 start while busy SHALL be ignored, with no effect on state, latch or code.
REQ-020 start in the DONE-to-IDLE cycle SHALL be ignored; back-to-back starts are therefore spaced at least DATA_W+2 cycles apart.
REQ-021 No tail bits SHALL be appended; trellis state after the word is discarded.

Reset
REQ-022 Asserted reset SHALL immediately force: IDLE, busy=0, done=0, code=0, history/shadow/counter=0.
REQ-023 Reset mid-ENC SHALL abort the word with no done pulse; the first start after deassertion SHALL be honoured normally.

Configuration
REQ-024 Macro CONV_ENC_SERIAL_EN SHALL, when defined, add outputs code_bit (2, {c0,c1} of current cycle) and code_bit_valid (1, high in every ENC cycle); both reset to 0.
REQ-025 Without CONV_ENC_SERIAL_EN these ports SHALL not exist; packed behaviour SHALL be identical in both builds.

Structure
REQ-026 Package conv_code_pkg SHALL hold DATA_W, K, G0, G1 defaults and the FSM state enumeration, shared with the viterbi decoder.
REQ-027 Sub-module conv_enc_core SHALL compute {c0,c1} combinationally from w, G0 and G1; the FSM, counter and registers stay in conv_encoder.

Verification
REQ-028 data=14'h0000, start -> done after 15 cycles, code=28'h0000000.
REQ-029 data=14'h2000 (impulse) -> code=28'hFB00000.
REQ-030 data=14'h0001 then, after done, data=14'h0000 -> first code=28'h0000003, second code=28'h0000000 (history cleared).
REQ-031 Start pulses at cycles 3 and 8 after a first start -> single done at cycle 15; code matches the first data only.
REQ-032 Reset asserted at ENC cycle 6 -> busy=0, code=0 immediately, no done; new start -> normal result 15 cycles later.
REQ-033 With CONV_ENC_SERIAL_EN and data=14'h2000 -> code_bit sequence 11,11,10,11, then zeros, code_bit_valid high for 14 cycles.
